// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the default address map for the bus decoder.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_e;

   // Default-slave states: ERR1 stalls the master, ERR2 completes the error.
   typedef enum logic [1:0] {
      DS_OKAY = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_e;

   // Four 256 MB windows at the bottom of the address space.
   localparam logic [3:0][31:0] DEF_SLAVE_BASE = {32'h3000_0000, 32'h2000_0000,
                                                  32'h1000_0000, 32'h0000_0000};
   localparam logic [3:0][31:0] DEF_SLAVE_MASK = {4{32'hF000_0000}};

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers decode misses with the two-cycle AHB ERROR response.
module ahb_default_slave
   import ahb_pkg::*;
(
   input  logic HCLK,
   input  logic HRESET,
   input  logic sel,
   input  logic HREADY_in,
   output logic HREADYOUT,
   output logic HRESP,
   output logic HERROR
);

   ds_state_e state;

   // A miss is only taken when the bus advances; outputs are registered alongside the state.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state     <= DS_OKAY;
         HREADYOUT <= 1'b1;
         HRESP     <= HRESP_OKAY;
         HERROR    <= 1'b0;
      end else begin
         case (state)
            DS_OKAY: begin
               if (sel && HREADY_in) begin
                  state     <= DS_ERR1;
                  HREADYOUT <= 1'b0;
                  HRESP     <= HRESP_ERROR;
                  HERROR    <= 1'b1;
               end
            end
            DS_ERR1: begin
               state     <= DS_ERR2;
               HREADYOUT <= 1'b1;
               HRESP     <= HRESP_ERROR;
               HERROR    <= 1'b0;
            end
            DS_ERR2: begin
               if (sel && HREADY_in) begin
                  state     <= DS_ERR1;
                  HREADYOUT <= 1'b0;
                  HRESP     <= HRESP_ERROR;
                  HERROR    <= 1'b1;
               end else begin
                  state     <= DS_OKAY;
                  HREADYOUT <= 1'b1;
                  HRESP     <= HRESP_OKAY;
                  HERROR    <= 1'b0;
               end
            end
            default: begin
               state     <= DS_OKAY;
               HREADYOUT <= 1'b1;
               HRESP     <= HRESP_OKAY;
               HERROR    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/ahb_bus_decoder.sv
// AHB address decoder with priority slave select, data-phase response mux and default slave.
module ahb_bus_decoder
   import ahb_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
   parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLAVE_MASK = DEF_SLAVE_MASK
) (
   input  logic                         HCLK,
   input  logic                         HRESET,
   input  logic [ADDR_W-1:0]            HADDR,
   input  logic [1:0]                   HTRANS,
   output logic [NUM_SLAVES-1:0]        HSELx,
   input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
   input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
   input  logic [NUM_SLAVES-1:0]        HRESP_S,
   output logic [DATA_W-1:0]            HRDATA,
   output logic                         HREADY,
   output logic                         HRESP,
   output logic                         HERROR
);

   logic [NUM_SLAVES-1:0]             match, hsel;
   logic [NUM_SLAVES-1:0]             dsel_oh;   // data-phase slave, one-hot or zero
   logic                              dsel_def;  // data phase owned by the default slave
   logic                              active, miss;
   logic [NUM_SLAVES-1:0][DATA_W-1:0] rd_term;
   logic [NUM_SLAVES-1:0]             rdy_term, rsp_term;
   logic [DATA_W-1:0]                 rd_or;
   logic                              rdy_or, rsp_or;
   logic                              ds_ready, ds_resp;

   // Address decode; a lower index masks every higher one on overlap.
   genvar i;
   for (i = 0; i < NUM_SLAVES; i++) begin : g_dec
      assign match[i] = (HADDR & SLAVE_MASK[i]) == SLAVE_BASE[i];
      if (i == 0) begin : g_first
         assign hsel[i] = match[i];
      end else begin : g_rest
         assign hsel[i] = match[i] & ~(|match[i-1:0]);
      end
   end

   assign HSELx  = HRESET ? '0 : hsel;
   assign active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
   assign miss   = active & ~(|match);

   // Data-phase owner advances only with the bus; IDLE/BUSY to a hole leaves nobody selected.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dsel_oh  <= '0;
         dsel_def <= 1'b0;
      end else if (HREADY) begin
         dsel_oh  <= hsel;
         dsel_def <= miss;
      end
   end

   // Per-slave response terms gated by the data-phase select.
   for (i = 0; i < NUM_SLAVES; i++) begin : g_mux
      assign rd_term[i]  = dsel_oh[i] ? HRDATA_S[i*DATA_W +: DATA_W] : '0;
      assign rdy_term[i] = dsel_oh[i] & HREADYOUT_S[i];
      assign rsp_term[i] = dsel_oh[i] & HRESP_S[i];
   end

   // OR-reduce the one-hot gated terms.
   always_comb begin
      rd_or  = '0;
      rdy_or = 1'b0;
      rsp_or = 1'b0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         rd_or  = rd_or | rd_term[k];
         rdy_or = rdy_or | rdy_term[k];
         rsp_or = rsp_or | rsp_term[k];
      end
   end

   // Final response select: default slave, mapped slave, or an idle zero-wait OKAY.
   always_comb begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = '0;
      if (dsel_def) begin
         HREADY = ds_ready;
         HRESP  = ds_resp;
      end else if (|dsel_oh) begin
         HREADY = rdy_or;
         HRESP  = rsp_or;
         HRDATA = rd_or;
      end
   end

   ahb_default_slave u_def (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .sel       (miss),
      .HREADY_in (HREADY),
      .HREADYOUT (ds_ready),
      .HRESP     (ds_resp),
      .HERROR    (HERROR)
   );

endmodule

// File: tb/tb_ahb_bus_decoder.sv
// Directed, table-driven bench for ahb_bus_decoder plus multi-cycle corner sequences.
module tb_ahb_bus_decoder;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  haddr;
   logic [1:0]   htrans;
   logic [127:0] hrdata_s;
   logic [3:0]   hreadyout_s, hresp_s;
   logic [3:0]   hsel, hsel2;
   logic [31:0]  hrdata, hrdata2;
   logic         hready, hresp, herror, hready2, hresp2, herror2;

   int n_applied = 0;
   int n_miss    = 0;

   always #5 clk = ~clk;

   ahb_bus_decoder dut (
      .HCLK(clk), .HRESET(rst), .HADDR(haddr), .HTRANS(htrans), .HSELx(hsel),
      .HRDATA_S(hrdata_s), .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s),
      .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .HERROR(herror)
   );

   // Overlapping map: slave 1 shares slave 0's window.
   ahb_bus_decoder #(
      .SLAVE_BASE({32'h3000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000})
   ) dut2 (
      .HCLK(clk), .HRESET(rst), .HADDR(haddr), .HTRANS(htrans), .HSELx(hsel2),
      .HRDATA_S(hrdata_s), .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s),
      .HRDATA(hrdata2), .HREADY(hready2), .HRESP(hresp2), .HERROR(herror2)
   );

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  trans;
      logic [3:0]  resp_s;
      logic [3:0]  hsel;
      logic [31:0] rdata;
      logic        rdy;
      logic        resp;
      logic        err;
   } vec_t;

   vec_t vt[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_dp(input string name, input logic rdy, input logic rsp,
                         input logic err, input logic [31:0] rd);
      chk({name, ".HREADY"}, {31'd0, hready}, {31'd0, rdy});
      chk({name, ".HRESP"},  {31'd0, hresp},  {31'd0, rsp});
      chk({name, ".HERROR"}, {31'd0, herror}, {31'd0, err});
      chk({name, ".HRDATA"}, hrdata, rd);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      htrans  = 2'd0;
      haddr   = 32'h8000_0000;
      hresp_s = 4'h0;
      hreadyout_s = 4'hF;
      tick();
      tick();
   endtask

   initial begin
      vt[0] = '{32'h2000_0010, 2'd2, 4'b0000, 4'b0100, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0};
      vt[1] = '{32'h0000_0004, 2'd2, 4'b0000, 4'b0001, 32'h1111_1111, 1'b1, 1'b0, 1'b0};
      vt[2] = '{32'h1FFF_FFFC, 2'd3, 4'b0000, 4'b0010, 32'h2222_2222, 1'b1, 1'b0, 1'b0};
      vt[3] = '{32'h3ABC_0000, 2'd2, 4'b1000, 4'b1000, 32'h4444_4444, 1'b1, 1'b1, 1'b0};
      vt[4] = '{32'h8000_0000, 2'd2, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
      vt[5] = '{32'h8000_0000, 2'd0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
      vt[6] = '{32'hF000_0000, 2'd1, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
      vt[7] = '{32'h2000_0000, 2'd0, 4'b0000, 4'b0100, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0};
      vt[8] = '{32'h4000_0000, 2'd3, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1};

      hrdata_s    = {32'h4444_4444, 32'hA5A5_A5A5, 32'h2222_2222, 32'h1111_1111};
      hreadyout_s = 4'hF;
      hresp_s     = 4'h0;
      haddr       = 32'h2000_0000;
      htrans      = 2'd2;
      rst         = 1'b1;

      // Reset: select forced off even for a mapped address.
      tick();
      tick();
      chk("rst.HSELx", {28'd0, hsel}, 32'h0);
      chk_dp("rst", 1'b1, 1'b0, 1'b0, 32'h0);

      rst    = 1'b0;
      htrans = 2'd0;
      haddr  = 32'h8000_0000;
      #1;
      chk("post_rst.HSELx", {28'd0, hsel}, 32'h0);
      tick();
      chk_dp("post_rst", 1'b1, 1'b0, 1'b0, 32'h0);

      // Single transfers from the table.
      for (int v = 0; v < 9; v++) begin
         haddr   = vt[v].addr;
         htrans  = vt[v].trans;
         hresp_s = vt[v].resp_s;
         #1;
         chk($sformatf("vec%0d.HSELx", v), {28'd0, hsel}, {28'd0, vt[v].hsel});
         tick();
         chk_dp($sformatf("vec%0d", v), vt[v].rdy, vt[v].resp, vt[v].err, vt[v].rdata);
         go_idle();
      end

      // Unmapped miss: ERR1 then ERR2 then back to OKAY.
      haddr  = 32'h8000_0000;
      htrans = 2'd2;
      tick();
      htrans = 2'd0;
      chk_dp("miss.err1", 1'b0, 1'b1, 1'b1, 32'h0);
      tick();
      chk_dp("miss.err2", 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
      chk_dp("miss.okay", 1'b1, 1'b0, 1'b0, 32'h0);
      go_idle();

      // Back-to-back misses; the second one is accepted in ERR2.
      haddr  = 32'h8000_0000;
      htrans = 2'd2;
      tick();
      chk_dp("b2b.err1a", 1'b0, 1'b1, 1'b1, 32'h0);
      tick();
      chk_dp("b2b.err2a", 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
      htrans = 2'd0;
      chk_dp("b2b.err1b", 1'b0, 1'b1, 1'b1, 32'h0);
      tick();
      chk_dp("b2b.err2b", 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
      chk_dp("b2b.okay", 1'b1, 1'b0, 1'b0, 32'h0);
      go_idle();

      // Slave 1 inserts three wait states while slave 3 waits in the address phase.
      hreadyout_s = 4'b1101;
      haddr       = 32'h1000_0000;
      htrans      = 2'd2;
      #1;
      chk("wait.HSELx0", {28'd0, hsel}, 32'h2);
      tick();
      haddr = 32'h3000_0000;
      for (int w = 0; w < 3; w++) begin
         #1;
         chk($sformatf("wait%0d.HSELx", w), {28'd0, hsel}, 32'h8);
         chk_dp($sformatf("wait%0d", w), 1'b0, 1'b0, 1'b0, 32'h2222_2222);
         if (w < 2) tick();
      end
      hreadyout_s = 4'hF;
      #1;
      chk_dp("wait.release", 1'b1, 1'b0, 1'b0, 32'h2222_2222);
      tick();
      htrans = 2'd0;
      chk_dp("wait.next", 1'b1, 1'b0, 1'b0, 32'h4444_4444);
      go_idle();

      // Reset during ERR1 aborts the error response.
      haddr  = 32'h8000_0000;
      htrans = 2'd2;
      tick();
      chk_dp("rst_err.err1", 1'b0, 1'b1, 1'b1, 32'h0);
      rst   = 1'b1;
      haddr = 32'h0000_0000;
      #1;
      chk("rst_err.HSELx", {28'd0, hsel}, 32'h0);
      tick();
      chk_dp("rst_err.after", 1'b1, 1'b0, 1'b0, 32'h0);
      rst    = 1'b0;
      htrans = 2'd0;
      #1;
      chk("rst_err.HSELx_rel", {28'd0, hsel}, 32'h1);
      tick();
      chk_dp("rst_err.okay", 1'b1, 1'b0, 1'b0, 32'h1111_1111);
      go_idle();

      // Reset during a slave wait state.
      hreadyout_s = 4'b1101;
      haddr       = 32'h1000_0000;
      htrans      = 2'd2;
      tick();
      chk_dp("rst_wait.stall", 1'b0, 1'b0, 1'b0, 32'h2222_2222);
      rst    = 1'b1;
      htrans = 2'd0;
      haddr  = 32'h8000_0000;
      tick();
      chk_dp("rst_wait.after", 1'b1, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;
      go_idle();

      // Overlapping windows: lowest index wins.
      haddr = 32'h0000_1234;
      #1;
      chk("ovl.HSELx", {28'd0, hsel2}, 32'h1);
      haddr = 32'h1000_0000;
      #1;
      chk("ovl.hole", {28'd0, hsel2}, 32'h0);
      haddr = 32'h3000_0000;
      #1;
      chk("ovl.top", {28'd0, hsel2}, 32'h8);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
      $finish;
   end

endmodule

// File: doc/ahb_bus_decoder.md
AHB_BUS_DECODER -- requirements
Module: ahb_bus_decoder

Interface
REQ-001 Parameter NUM_SLAVES, default 4: number of mapped slave ports, range 1..16.
REQ-002 Parameter ADDR_W, default 32: HADDR width.
REQ-003 Parameter DATA_W, default 32: read-data width.
REQ-004 Parameter SLAVE_BASE, default {0x0000_0000, 0x1000_0000, 0x2000_0000, 0x3000_0000}: per-slave base address array, ADDR_W bits each.
REQ-005 Parameter SLAVE_MASK, default 0xF000_0000 for all entries: per-slave compare mask.
REQ-006 HCLK  in  1  bus clock; all state changes on its rising edge.
REQ-007 HRESET  in  1  reset, synchronous, active-high.
REQ-008 HADDR  in  ADDR_W  address-phase address.
REQ-009 HTRANS  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-010 HSELx  out  NUM_SLAVES  one-hot address-phase slave select.
REQ-011 HRDATA_S  in  NUM_SLAVES*DATA_W  slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
REQ-012 HREADYOUT_S  in  NUM_SLAVES  per-slave ready.
REQ-013 HRESP_S  in  NUM_SLAVES  per-slave response: 0=OKAY, 1=ERROR.
REQ-014 HRDATA  out  DATA_W  muxed read data to master.
REQ-015 HREADY  out  1  muxed ready; also drives the decoder's own data-phase advance.
REQ-016 HRESP  out  1  muxed response.
REQ-017 HERROR  out  1  one-cycle decode-miss flag.

Function
REQ-018 Slave i SHALL match when (HADDR & SLAVE_MASK[i]) == SLAVE_BASE[i].
REQ-019 On overlapping matches the lowest index SHALL win; HSELx SHALL be one-hot or all-zero.
REQ-020 HSELx SHALL be combinational from HADDR with zero latency and forced to 0 while HRESET=1.
REQ-021 A miss SHALL be no slave matching while HTRANS[1]=1; it selects the internal default slave.
REQ-022 Data-phase select dsel (NUM_SLAVES+1 entries incl. default, or none) SHALL load on a rising edge with HREADY=1; it holds while HREADY=0.
REQ-023 With IDLE/BUSY in the captured address phase, dsel SHALL be none when nothing matched, else the matched slave.
REQ-024 When dsel=slave i: HRDATA=HRDATA_S[i], HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i].
REQ-025 When dsel=none: HREADY=1, HRESP=0, HRDATA=0.
REQ-026 Default-slave FSM states SHALL be OKAY, ERR1, ERR2.
REQ-027 In OKAY, a captured miss SHALL move to ERR1; otherwise stay in OKAY.
REQ-028 ERR1 SHALL drive HREADY=0, HRESP=1, HRDATA=0, then go unconditionally to ERR2.
REQ-029 ERR2 SHALL drive HREADY=1, HRESP=1, HRDATA=0; a new miss accepted there SHALL go to ERR1, otherwise to OKAY.
REQ-030 HERROR SHALL be 1 exactly in ERR1 cycles.
REQ-031 A slave response SHALL never be sampled while the FSM is in ERR1 or ERR2.
REQ-032 A mapped slave's wait states SHALL be passed through unmodified, with no added latency.

Reset
REQ-033 While HRESET=1 at a rising HCLK edge: dsel=none, FSM=OKAY.
REQ-034 After reset, outputs SHALL be HREADY=1, HRESP=0, HRDATA=0, HERROR=0, HSELx=0.
REQ-035 Reset asserted in ERR1/ERR2 or during a slave wait state SHALL abort the transfer; the first post-reset cycle SHALL show the REQ-034 values.

Structure
REQ-036 Shared package ahb_pkg SHALL hold the HTRANS and HRESP encodings, the default-slave state enum and the address-map default constants.
REQ-037 The default-slave FSM SHALL be sub-module ahb_default_slave (ports HCLK, HRESET, sel, HREADY_in, HREADYOUT, HRESP, HERROR).
REQ-038 The decode and response mux SHALL be generate-loops over NUM_SLAVES.

Verification
REQ-039 Mapped read: HADDR=0x2000_0010, NONSEQ, slave2 HREADYOUT=1, HRDATA_S[2]=0xA5A5_A5A5 -> HSELx=0100 same cycle; next cycle HRDATA=0xA5A5_A5A5, HREADY=1, HRESP=0.
REQ-040 Unmapped: HADDR=0x8000_0000, NONSEQ -> HSELx=0; next cycle HREADY=0/HRESP=1/HERROR=1; following cycle HREADY=1/HRESP=1/HERROR=0.
REQ-041 Back-to-back misses: two NONSEQ to 0x8000_0000, the second presented in ERR2 -> response sequence ERR1, ERR2, ERR1, ERR2, then OKAY.
REQ-042 Wait states: slave1 holds HREADYOUT=0 for 3 cycles -> HREADY=0 for 3 cycles; dsel and HRDATA mux unchanged while a new HADDR to slave3 is held.
REQ-043 IDLE to 0x8000_0000 -> zero-wait OKAY, HERROR stays 0.
REQ-044 HRESET=1 asserted during ERR1 -> next cycle HREADY=1, HRESP=0, HERROR=0, FSM=OKAY; overlap test with BASE1=BASE0 -> HSELx=0001.
